// File: rtl/fetch_ctrl.sv
// Instruction fetch control: program counter, instruction register, halt request,
// retired-instruction counter and a sticky flag for illegal stage encodings.
module fetch_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              waits,
  input  logic              fetcha,
  input  logic              fetchb,
  input  logic              execa,
  input  logic              execb,
  input  logic              load_pc,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic              halt,
  output logic [15:0]       instr_count,
  output logic              stage_err
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned OP_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              halt_q, halt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              stage_legal;
  logic [OP_W-1:0]   opcode;

  assign stage_legal = $onehot({waits, fetcha, fetchb, execa, execb});
  assign opcode      = ir_q[DATA_W-1 -: OP_W];

  // Next-state: exactly one stage acts per edge; an illegal word freezes everything.
  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    halt_d = halt_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (!err_q) begin
      if (!stage_legal) begin
        err_d = 1'b1;
      end else if (waits) begin
        if (load_pc) pc_d = load_addr;
        halt_d = 1'b0;
      end else if (fetchb) begin
        ir_d = mem_rdata;
        pc_d = pc_q + ADDR_W'(1);
      end else if (execa) begin
        if (opcode == HALT_OP) halt_d = 1'b1;
      end else if (execb) begin
        if (jump) pc_d = jump_addr;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      ir_q   <= '0;
      halt_q <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      halt_q <= halt_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Read enable follows the stage directly so the memory sees it in fetcha.
  assign mem_re      = fetcha & ~err_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign halt        = halt_q;
  assign instr_count = cnt_q;
  assign stage_err   = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a behavioural instruction memory plus
// hand-stepped stage sequences with precomputed expected register values.
module tb_fetch_ctrl;

  localparam logic [4:0] ST_W  = 5'b10000;
  localparam logic [4:0] ST_FA = 5'b01000;
  localparam logic [4:0] ST_FB = 5'b00100;
  localparam logic [4:0] ST_EA = 5'b00010;
  localparam logic [4:0] ST_EB = 5'b00001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        waits = 1'b1, fetcha = 1'b0, fetchb = 1'b0, execa = 1'b0, execb = 1'b0;
  logic        load_pc = 1'b0;
  logic [7:0]  load_addr = '0;
  logic        jump = 1'b0;
  logic [7:0]  jump_addr = '0;
  logic [15:0] mem_rdata = '0;
  logic [7:0]  mem_addr;
  logic        mem_re;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        halt;
  logic [15:0] instr_count;
  logic        stage_err;

  logic [15:0] mem [256];
  int n_checks = 0;
  int n_errors = 0;

  fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .waits(waits), .fetcha(fetcha), .fetchb(fetchb), .execa(execa), .execb(execb),
    .load_pc(load_pc), .load_addr(load_addr),
    .jump(jump), .jump_addr(jump_addr),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_re(mem_re),
    .pc(pc), .ir(ir), .halt(halt), .instr_count(instr_count), .stage_err(stage_err)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: data one posedge after the address.
  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] st);
    {waits, fetcha, fetchb, execa, execb} = st;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [4:0] st);
    @(negedge clk);
    drive(st);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'hF000;
    mem[8'hFF] = 16'h2BCD;
    mem[8'h40] = 16'hF040;

    // Reset values
    #1;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_ir", 32'(ir), 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_cnt", 32'(instr_count), 32'h0);
    check("rst_err", 32'(stage_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic fetch of word 0
    step(ST_W);
    @(negedge clk);
    {waits, fetcha, fetchb, execa, execb} = ST_FA;
    #1;
    check("fa_mem_re", 32'(mem_re), 32'h1);
    check("fa_mem_addr", 32'(mem_addr), 32'h0);
    @(posedge clk); #1;
    step(ST_FB);
    check("b1_ir", 32'(ir), 32'h1234);
    check("b1_pc", 32'(pc), 32'h1);
    step(ST_EA);
    check("b1_halt", 32'(halt), 32'h0);
    step(ST_EB);
    check("b1_cnt", 32'(instr_count), 32'h1);

    // Load 0xFF, fetch wraps pc to 0; load_pc outside waits is ignored
    load_pc = 1'b1; load_addr = 8'hFF;
    step(ST_W);
    check("ld_pc", 32'(pc), 32'hFF);
    load_addr = 8'h55;
    step(ST_FA);
    check("ld_ignored", 32'(pc), 32'hFF);
    load_pc = 1'b0;
    step(ST_FB);
    check("wrap_pc", 32'(pc), 32'h00);
    check("wrap_ir", 32'(ir), 32'h2BCD);
    step(ST_EA);
    step(ST_EB);
    check("wrap_cnt", 32'(instr_count), 32'h2);

    // Halt opcode at address 1
    load_pc = 1'b1; load_addr = 8'h01;
    step(ST_W);
    load_pc = 1'b0;
    step(ST_FA);
    step(ST_FB);
    check("h_ir", 32'(ir), 32'hF000);
    check("h_pre", 32'(halt), 32'h0);
    step(ST_EA);
    check("h_execa", 32'(halt), 32'h1);
    step(ST_EB);
    check("h_execb", 32'(halt), 32'h1);
    @(negedge clk);
    check("h_execb_neg", 32'(halt), 32'h1);
    drive(ST_W);
    check("h_clear", 32'(halt), 32'h0);
    check("h_cnt", 32'(instr_count), 32'h3);

    // Jump in execa ignored, jump in execb taken
    step(ST_FA);
    step(ST_FB);
    check("j_pc_fb", 32'(pc), 32'h3);
    jump = 1'b1; jump_addr = 8'h77;
    step(ST_EA);
    check("j_execa_ign", 32'(pc), 32'h3);
    jump_addr = 8'h40;
    step(ST_EB);
    check("j_pc", 32'(pc), 32'h40);
    jump = 1'b0;
    step(ST_W);
    @(negedge clk);
    {waits, fetcha, fetchb, execa, execb} = ST_FA;
    #1;
    check("j_mem_addr", 32'(mem_addr), 32'h40);
    check("j_pc_fa", 32'(pc), 32'h40);
    @(posedge clk); #1;

    // Halt instruction combined with a taken jump
    step(ST_FB);
    check("hj_ir", 32'(ir), 32'hF040);
    step(ST_EA);
    jump = 1'b1; jump_addr = 8'h10;
    step(ST_EB);
    jump = 1'b0;
    check("hj_halt", 32'(halt), 32'h1);
    check("hj_pc", 32'(pc), 32'h10);
    check("hj_cnt", 32'(instr_count), 32'h5);
    step(ST_W);
    check("hj_halt_clr", 32'(halt), 32'h0);

    // Illegal stage word freezes state until reset
    step(ST_FA | ST_EA);
    check("se_err", 32'(stage_err), 32'h1);
    check("se_mem_re", 32'(mem_re), 32'h0);
    step(ST_FB);
    check("se_ir", 32'(ir), 32'hF040);
    check("se_pc", 32'(pc), 32'h10);
    step(ST_EA);
    check("se_halt", 32'(halt), 32'h0);
    jump = 1'b1; jump_addr = 8'h33;
    step(ST_EB);
    jump = 1'b0;
    check("se_pc2", 32'(pc), 32'h10);
    check("se_cnt", 32'(instr_count), 32'h5);
    check("se_sticky", 32'(stage_err), 32'h1);
    #2;
    {waits, fetcha, fetchb, execa, execb} = ST_W;
    rst = 1'b1;
    #1;
    check("se_rst_err", 32'(stage_err), 32'h0);
    check("se_rst_pc", 32'(pc), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Counter saturation: execb alone retires one instruction per edge
    step(ST_EB);
    repeat (65533) @(posedge clk);
    #1;
    check("sat_pre", 32'(instr_count), 32'hFFFE);
    step(ST_W); step(ST_FA); step(ST_FB); step(ST_EA); step(ST_EB);
    check("sat_ffff", 32'(instr_count), 32'hFFFF);
    step(ST_W); step(ST_FA); step(ST_FB); step(ST_EA); step(ST_EB);
    check("sat_hold", 32'(instr_count), 32'hFFFF);
    check("sat_ir", 32'(ir), 32'hF000);
    check("sat_halt", 32'(halt), 32'h1);

    // Asynchronous reset in the middle of fetchb
    step(ST_FA);
    @(negedge clk);
    {waits, fetcha, fetchb, execa, execb} = ST_FB;
    #2;
    rst = 1'b1;
    #1;
    check("ar_pc", 32'(pc), 32'h0);
    check("ar_mem_addr", 32'(mem_addr), 32'h0);
    check("ar_ir", 32'(ir), 32'h0);
    check("ar_halt", 32'(halt), 32'h0);
    check("ar_cnt", 32'(instr_count), 32'h0);
    check("ar_err", 32'(stage_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8: program counter and memory address width.
REQ-002 Parameter DATA_W, default 16: instruction width; opcode is the upper 4 bits, ir[DATA_W-1:DATA_W-4].
REQ-003 Parameter HALT_OP, default 4'hF: opcode that requests halt.
REQ-004 clk  input  1  clock; all state in this block updates on posedge; the stage sequencer changes stage on negedge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 waits, fetcha, fetchb, execa, execb  input  1 each  one-hot stage indication from the stage sequencer.
REQ-007 load_pc  input  1  load request for the program counter, honoured only in waits.
REQ-008 load_addr  input  ADDR_W  program counter value for load_pc.
REQ-009 jump  input  1  branch-taken indication from the execute datapath, sampled in execb.
REQ-010 jump_addr  input  ADDR_W  branch target.
REQ-011 mem_rdata  input  DATA_W  instruction memory read data, valid one posedge after mem_re/mem_addr are presented.
REQ-012 mem_addr  output  ADDR_W  instruction memory address.
REQ-013 mem_re  output  1  instruction memory read enable.
REQ-014 pc  output  ADDR_W  program counter.
REQ-015 ir  output  DATA_W  instruction register.
REQ-016 halt  output  1  halt request to the stage sequencer.
REQ-017 instr_count  output  16  retired instruction count.
REQ-018 stage_err  output  1  sticky stage-encoding error flag.

Function
REQ-019 mem_addr SHALL equal pc at all times; mem_re SHALL be combinationally equal to fetcha & ~stage_err.
REQ-020 A stage word is legal when exactly one of the five stage inputs is 1; at a posedge with an illegal word stage_err SHALL be set to 1.
REQ-021 stage_err SHALL stay set until rst, and while it is set pc, ir, halt and instr_count SHALL hold.
REQ-022 waits, posedge: if load_pc, pc <= load_addr; halt <= 0; ir holds.
REQ-023 fetcha, posedge: no register update (memory read in flight).
REQ-024 fetchb, posedge: ir <= mem_rdata; pc <= pc + 1, modulo 2^ADDR_W (all-ones wraps to 0).
REQ-025 execa, posedge: halt <= 1 if ir opcode == HALT_OP, else halt holds.
REQ-026 execb, posedge: if jump, pc <= jump_addr; instr_count <= instr_count + 1, saturating at 16'hFFFF.
REQ-027 halt SHALL be stable from the execa posedge through the following execb negedge, so the sequencer samples it at the execb-to-next transition.
REQ-028 load_pc outside waits and jump outside execb SHALL be ignored.
REQ-029 A HALT_OP instruction with jump asserted SHALL both assert halt and load jump_addr into pc, so fetch resumes at jump_addr after the next run.

Reset
REQ-030 When rst is asserted, at any time including mid-instruction, pc, ir, instr_count and halt SHALL go to 0 and stage_err SHALL be cleared, without waiting for clk.
REQ-031 After rst is released, the first update SHALL occur at the first posedge, using the stage inputs present at that edge.

Verification
REQ-032 Reset; memory[0]=16'h1234; stages waits->fetcha->fetchb->execa->execb -> ir=16'h1234, pc=1, halt=0, instr_count=1.
REQ-033 load_pc=1 with load_addr=8'hFF in waits; one fetch cycle -> pc wraps to 8'h00, and ir holds the word at address 8'hFF.
REQ-034 Fetch of 16'hF000 -> halt=1 from the execa posedge through execb; the sequencer returns to waits; halt=0 at the first waits posedge.
REQ-035 jump=1 with jump_addr=8'h40 in execb -> pc=8'h40 and mem_addr=8'h40 in the next fetcha; jump=1 in execa -> pc unchanged.
REQ-036 fetcha and execa both driven to 1 at a posedge -> stage_err=1; pc, ir and instr_count frozen over the following cycles; rst clears stage_err to 0.
REQ-037 instr_count preset to 16'hFFFE by running instructions, then two more instructions -> instr_count=16'hFFFF, not 0; rst asserted mid-fetchb -> all outputs 0 immediately.
